// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Command front-end for a combinational ALU (add, sub, mul, shift, div).
//   Tagged commands enter through a small FIFO. Each legal command is driven
//   onto registered ALU select/operand lines. After SETTLE_CYCLES edges the ALU
//   outputs are captured into a response that is held under valid/ready.
//   Illegal opcodes and divide-by-zero never reach the ALU. They produce an
//   error response directly.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake (ready = FIFO not full)
//   cmd_op/opa/opb/cin/tag     command fields
//   alu_sel/opa/opb/cin/sub    registered drive to the ALU
//   alu_y1/y2/y3/cout/
//   alu_carry_out/alu_m        ALU results, sampled only on the capture edge
//   rsp_valid/rsp_ready        response handshake
//   rsp_lo/hi/flags/tag        response payload, flags = {error, overflow, carry}
module alu_issue_ctrl #(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_opa,
  input  logic [15:0] cmd_opb,
  input  logic        cmd_cin,
  input  logic [3:0]  cmd_tag,
  output logic [2:0]  alu_sel,
  output logic [15:0] alu_opa,
  output logic [15:0] alu_opb,
  output logic        alu_cin,
  output logic        alu_sub,
  input  logic [15:0] alu_y1,
  input  logic [31:0] alu_y2,
  input  logic [15:0] alu_y3,
  input  logic        alu_cout,
  input  logic        alu_carry_out,
  input  logic        alu_m,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_lo,
  output logic [15:0] rsp_hi,
  output logic [2:0]  rsp_flags,
  output logic [3:0]  rsp_tag
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(FIFO_DEPTH);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_SHF = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4;

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t state, state_nxt;

  logic [2:0]  fifo_op  [FIFO_DEPTH];
  logic [15:0] fifo_opa [FIFO_DEPTH];
  logic [15:0] fifo_opb [FIFO_DEPTH];
  logic        fifo_cin [FIFO_DEPTH];
  logic [3:0]  fifo_tag [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [SET_W-1:0] settle_cnt;
  logic [3:0]       cur_tag;

  logic        push, pop, issue_slot, fifo_nempty;
  logic        load_alu, load_err, capture, rsp_done;
  logic [2:0]  head_op;
  logic [15:0] head_opa, head_opb;
  logic        head_cin;
  logic [3:0]  head_tag;
  logic        head_div0, head_err;

  // Maps the ALU outputs for the selected operation onto {flags, hi, lo}.
  function automatic logic [34:0] map_rsp(
    input logic [2:0]  sel,
    input logic [15:0] y1,
    input logic [31:0] y2,
    input logic [15:0] y3,
    input logic        cout,
    input logic        carry,
    input logic        ovf
  );
    logic [34:0] r;
    r = '0;
    unique case (sel)
      OP_ADD:  r = {2'b00, cout, 16'h0000, y1};
      OP_SUB:  r = {1'b0, ovf, carry, 16'h0000, y1};
      OP_MUL:  r = {3'b000, y2};
      OP_SHF:  r = {3'b000, y3, y1};
      OP_DIV:  r = {3'b000, y3, y1};
      default: r = {3'b100, 32'h0000_0000};
    endcase
    return r;
  endfunction

  assign cmd_ready   = (count != FULL_CNT);
  assign push        = cmd_valid && cmd_ready;
  assign fifo_nempty = (count != '0);

  assign head_op   = fifo_op[rd_ptr];
  assign head_opa  = fifo_opa[rd_ptr];
  assign head_opb  = fifo_opb[rd_ptr];
  assign head_cin  = fifo_cin[rd_ptr];
  assign head_tag  = fifo_tag[rd_ptr];
  assign head_div0 = (head_op == OP_DIV) && (head_opb == 16'h0000);
  assign head_err  = (head_op > OP_DIV) || head_div0;

  // A new command may start from IDLE, or on the edge that retires the
  // current response (back-to-back issue without passing through IDLE).
  always_comb begin
    state_nxt  = state;
    issue_slot = 1'b0;
    capture    = 1'b0;
    rsp_done   = 1'b0;
    unique case (state)
      IDLE: begin
        issue_slot = 1'b1;
      end
      SETTLE: begin
        if (settle_cnt == SET_W'(1)) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_done   = 1'b1;
          issue_slot = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    pop      = issue_slot && fifo_nempty;
    load_err = pop && head_err;
    load_alu = pop && !head_err;
    if (load_err) begin
      state_nxt = RESP;
    end else if (load_alu) begin
      state_nxt = SETTLE;
    end
  end

  // Stage 0: FIFO storage and control state
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr]  <= cmd_op;
      fifo_opa[wr_ptr] <= cmd_opa;
      fifo_opb[wr_ptr] <= cmd_opb;
      fifo_cin[wr_ptr] <= cmd_cin;
      fifo_tag[wr_ptr] <= cmd_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      settle_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
      if (load_alu) begin
        settle_cnt <= SETTLE_LOAD;
      end else if (state == SETTLE) begin
        settle_cnt <= settle_cnt - SET_W'(1);
      end
    end
  end

  // Stage 1: ALU drive registers, held between commands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_sel <= 3'b000;
      alu_opa <= '0;
      alu_opb <= '0;
      alu_cin <= 1'b0;
      alu_sub <= 1'b0;
    end else if (load_alu) begin
      alu_sel <= head_op;
      alu_opa <= head_opa;
      alu_opb <= head_opb;
      alu_cin <= head_cin;
      alu_sub <= (head_op == OP_SUB);
    end
  end

  always_ff @(posedge clk) begin
    if (load_alu) cur_tag <= head_tag;
  end

  // Stage 2: response capture (ALU sample or screened error)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_lo    <= '0;
      rsp_hi    <= '0;
      rsp_flags <= '0;
      rsp_tag   <= '0;
    end else begin
      if (rsp_done) rsp_valid <= 1'b0;
      if (load_err) begin
        rsp_valid <= 1'b1;
        rsp_lo    <= head_div0 ? 16'hFFFF : 16'h0000;
        rsp_hi    <= head_div0 ? head_opa : 16'h0000;
        rsp_flags <= 3'b100;
        rsp_tag   <= head_tag;
      end else if (capture) begin
        rsp_valid <= 1'b1;
        {rsp_flags, rsp_hi, rsp_lo} <= map_rsp(alu_sel, alu_y1, alu_y2, alu_y3,
                                               alu_cout, alu_carry_out, alu_m);
        rsp_tag   <= cur_tag;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: stand-in ALU with a settle window, a
// transaction-level reference model, a per-cycle compare process, and
// directed scenarios with hand-computed expectations.
module tb_alu_issue_ctrl;

  localparam int FIFO_DEPTH    = 4;
  localparam int SETTLE_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [15:0] cmd_opa = '0;
  logic [15:0] cmd_opb = '0;
  logic        cmd_cin = 1'b0;
  logic [3:0]  cmd_tag = '0;
  logic [2:0]  alu_sel;
  logic [15:0] alu_opa, alu_opb;
  logic        alu_cin, alu_sub;
  logic [15:0] alu_y1, alu_y3;
  logic [31:0] alu_y2;
  logic        alu_cout, alu_carry_out, alu_m;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_lo, rsp_hi;
  logic [2:0]  rsp_flags;
  logic [3:0]  rsp_tag;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  alu_issue_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .SETTLE_CYCLES(SETTLE_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_opa(cmd_opa), .cmd_opb(cmd_opb), .cmd_cin(cmd_cin), .cmd_tag(cmd_tag),
    .alu_sel(alu_sel), .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_cin(alu_cin),
    .alu_sub(alu_sub), .alu_y1(alu_y1), .alu_y2(alu_y2), .alu_y3(alu_y3),
    .alu_cout(alu_cout), .alu_carry_out(alu_carry_out), .alu_m(alu_m),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_lo(rsp_lo),
    .rsp_hi(rsp_hi), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- stand-in ALU ----------------
  // Outputs are garbage (inverted) until the inputs have been stable long
  // enough, so a capture on the wrong edge is visible.
  int age = 0;
  logic [36:0] alu_in_prev = '0;
  initial forever begin
    @(negedge clk);
    if ({alu_sel, alu_opa, alu_opb, alu_cin, alu_sub} !== alu_in_prev) begin
      age = 0;
      alu_in_prev = {alu_sel, alu_opa, alu_opb, alu_cin, alu_sub};
    end else begin
      age++;
    end
  end

  always_comb begin
    logic [16:0] s;
    logic [15:0] d, q, r;
    s = {1'b0, alu_opa} + {1'b0, alu_opb} + 17'(alu_cin);
    d = alu_opa - alu_opb;
    q = (alu_opb != 0) ? alu_opa / alu_opb : 16'h0;
    r = (alu_opb != 0) ? alu_opa % alu_opb : 16'h0;
    alu_y2 = 32'(alu_opa) * 32'(alu_opb);
    case (alu_sel)
      3'd1:    alu_y1 = d;
      3'd3:    alu_y1 = alu_opa >> alu_opb;
      3'd4:    alu_y1 = q;
      default: alu_y1 = s[15:0];
    endcase
    alu_y3 = (alu_sel == 3'd4) ? r : (alu_opa << alu_opb);
    alu_cout = s[16];
    alu_carry_out = (alu_opa < alu_opb);
    alu_m = (alu_opa[15] ^ alu_opb[15]) & (d[15] ^ alu_opa[15]);
    if (age < SETTLE_CYCLES - 1) begin
      alu_y1 = ~alu_y1; alu_y2 = ~alu_y2; alu_y3 = ~alu_y3;
      alu_cout = ~alu_cout; alu_carry_out = ~alu_carry_out; alu_m = ~alu_m;
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed {logic [2:0] op; logic [15:0] a; logic [15:0] b; logic cin; logic [3:0] tag;} cmd_t;
  typedef struct packed {logic [15:0] lo; logic [15:0] hi; logic [2:0] flags; logic [3:0] tag;} rsp_t;

  function automatic bit is_err(input cmd_t c);
    return (c.op > 3'd4) || (c.op == 3'd4 && c.b == 16'h0);
  endfunction

  function automatic rsp_t exp_rsp(input cmd_t c);
    rsp_t r;
    int unsigned s;
    int sd;
    r = '0;
    r.tag = c.tag;
    case (c.op)
      3'd0: begin
        s = 32'(c.a) + 32'(c.b) + 32'(c.cin);
        r.lo = 16'(s);
        r.flags[0] = (s > 65535);
      end
      3'd1: begin
        r.lo = c.a - c.b;
        r.flags[0] = (c.a < c.b);
        sd = int'($signed(c.a)) - int'($signed(c.b));
        r.flags[1] = (sd > 32767) || (sd < -32768);
      end
      3'd2: {r.hi, r.lo} = 32'(c.a) * 32'(c.b);
      3'd3: begin r.lo = c.a >> c.b; r.hi = c.a << c.b; end
      3'd4: begin
        if (c.b == 16'h0) begin r.lo = 16'hFFFF; r.hi = c.a; r.flags = 3'b100; end
        else begin r.lo = c.a / c.b; r.hi = c.a % c.b; end
      end
      default: r.flags = 3'b100;
    endcase
    return r;
  endfunction

  cmd_t mq[$];
  rsp_t cur_rsp = '0;
  bit holding = 1'b0;
  int ready_edge = 0;
  int edge_m = 0;
  bit m_valid = 1'b0;
  bit m_ready = 1'b1;
  logic [36:0] m_alu = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete(); holding = 0; m_valid = 0; m_ready = 1; m_alu = '0; cur_rsp = '0;
    end else begin
      int sz;
      cmd_t c;
      sz = mq.size();
      if (m_valid && rsp_ready) holding = 0;
      if (!holding && sz > 0) begin
        c = mq.pop_front();
        holding = 1;
        cur_rsp = exp_rsp(c);
        if (is_err(c)) begin
          ready_edge = edge_m;
        end else begin
          ready_edge = edge_m + SETTLE_CYCLES;
          m_alu = {c.op, c.a, c.b, c.cin, c.op == 3'd1};
        end
      end
      if (cmd_valid && sz < FIFO_DEPTH) begin
        c.op = cmd_op; c.a = cmd_opa; c.b = cmd_opb; c.cin = cmd_cin; c.tag = cmd_tag;
        mq.push_back(c);
      end
      m_ready = (mq.size() < FIFO_DEPTH);
      m_valid = holding && (edge_m >= ready_edge);
      edge_m++;
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("cmd_ready", 64'(cmd_ready), 64'(m_ready));
      check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
      if (m_valid) check("rsp_payload", 64'({rsp_lo, rsp_hi, rsp_flags, rsp_tag}), 64'(cur_rsp));
      check("alu_regs", 64'({alu_sel, alu_opa, alu_opb, alu_cin, alu_sub}), 64'(m_alu));
    end
  end

  // Tags of DUT responses, logged on the cycle before each handshake edge.
  logic [3:0] dut_tags[$];
  initial forever begin
    @(negedge clk);
    if (rst_n && rsp_valid && rsp_ready) dut_tags.push_back(rsp_tag);
  end

  // ---------------- directed helpers ----------------
  task automatic directed(input string nm, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic cin, input logic [3:0] tag,
                          input logic [15:0] e_lo, input logic [15:0] e_hi,
                          input logic [2:0] e_fl, input int e_lat,
                          input logic [2:0] e_sel, input logic e_sub);
    int n;
    bit got;
    @(posedge clk); #1;
    check({nm, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
    cmd_op = op; cmd_opa = a; cmd_opb = b; cmd_cin = cin; cmd_tag = tag; cmd_valid = 1'b1;
    @(posedge clk); #1;
    n = cyc;
    cmd_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (cyc == n + 1) begin
        check({nm, "_alu_sel"}, 64'(alu_sel), 64'(e_sel));
        check({nm, "_alu_sub"}, 64'(alu_sub), 64'(e_sub));
      end
      if (rsp_valid) got = 1;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=no_rsp_valid required=rsp_valid", nm);
    end else begin
      check({nm, "_latency"}, 64'(cyc - n), 64'(e_lat));
      check({nm, "_lo"}, 64'(rsp_lo), 64'(e_lo));
      check({nm, "_hi"}, 64'(rsp_hi), 64'(e_hi));
      check({nm, "_flags"}, 64'(rsp_flags), 64'(e_fl));
      check({nm, "_tag"}, 64'(rsp_tag), 64'(tag));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #3 rst_n = 1'b0;
    chk_en = 1'b1;
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp", 64'({rsp_lo, rsp_hi, rsp_flags, rsp_tag}), 64'(0));
    check("rst_alu", 64'({alu_sel, alu_opa, alu_opb, alu_cin, alu_sub}), 64'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    directed("add",   3'd0, 16'd10,    16'd20, 1'b0, 4'd1, 16'd30,    16'd0,     3'b000, 3, 3'd0, 1'b0);
    directed("sub",   3'd1, 16'd25,    16'd11, 1'b0, 4'd2, 16'd14,    16'd0,     3'b000, 3, 3'd1, 1'b1);
    directed("mul",   3'd2, 16'd8,     16'd8,  1'b0, 4'd3, 16'd64,    16'd0,     3'b000, 3, 3'd2, 1'b0);
    directed("shift", 3'd3, 16'hFF12,  16'd3,  1'b0, 4'd4, 16'h1FE2,  16'hF890,  3'b000, 3, 3'd3, 1'b0);
    directed("div",   3'd4, 16'd15,    16'd2,  1'b0, 4'd5, 16'd7,     16'd1,     3'b000, 3, 3'd4, 1'b0);
    directed("div0",  3'd4, 16'd9,     16'd0,  1'b0, 4'd6, 16'hFFFF,  16'd9,     3'b100, 1, 3'd4, 1'b0);
    directed("ill",   3'd6, 16'd5,     16'd5,  1'b0, 4'd7, 16'd0,     16'd0,     3'b100, 1, 3'd4, 1'b0);
    directed("addc",  3'd0, 16'hFFFF,  16'd1,  1'b1, 4'd8, 16'd1,     16'd0,     3'b001, 3, 3'd0, 1'b0);

    // Backpressure: five accepted, sixth held until a response retires.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    dut_tags.delete();
    for (int i = 1; i <= 5; i++) begin
      cmd_op = 3'(i - 1); cmd_opa = 16'(100 + i); cmd_opb = 16'd3; cmd_cin = 1'b0;
      cmd_tag = 4'(i); cmd_valid = 1'b1;
      check("bp_ready_before_full", 64'(cmd_ready), 64'(1));
      @(posedge clk); #1;
    end
    check("bp_full", 64'(cmd_ready), 64'(0));
    cmd_op = 3'd5; cmd_tag = 4'd6;
    repeat (4) begin
      @(posedge clk); #1;
      check("bp_held_ready", 64'(cmd_ready), 64'(0));
      check("bp_held_tag", 64'({rsp_valid, rsp_tag}), 64'({1'b1, 4'd1}));
    end
    rsp_ready = 1'b1;
    begin
      bit acc;
      acc = 0;
      for (int k = 0; k < 20 && !acc; k++) begin
        if (cmd_ready) acc = 1;
        @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      if (!acc) begin
        checks++; failures++;
        $display("FAIL bp_sixth_accept actual=never required=accepted");
      end
    end
    for (int k = 0; k < 100 && dut_tags.size() < 6; k++) @(posedge clk);
    check("bp_count", 64'(dut_tags.size()), 64'(6));
    for (int i = 0; i < 6 && i < dut_tags.size(); i++) check("bp_order", 64'(dut_tags[i]), 64'(i + 1));

    // Reset during SETTLE with two commands queued.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      cmd_op = 3'd0; cmd_opa = 16'd3; cmd_opb = 16'd4; cmd_cin = 1'b0;
      cmd_tag = 4'(10 + i); cmd_valid = 1'b1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("mid_rst_rsp", 64'({rsp_lo, rsp_hi, rsp_flags, rsp_tag}), 64'(0));
    check("mid_rst_alu", 64'({alu_sel, alu_opa, alu_opb, alu_cin, alu_sub}), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("post_rst_no_stale", 64'(rsp_valid), 64'(0));
    end
    directed("post_rst_add", 3'd0, 16'd1, 16'd1, 1'b0, 4'd9, 16'd2, 16'd0, 3'b000, 3, 3'd0, 1'b0);

    // Randomized traffic checked every cycle by the model.
    repeat (600) begin
      @(posedge clk); #1;
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_op    = 3'($urandom_range(0, 7));
      cmd_opa   = 16'($urandom);
      cmd_opb   = ($urandom_range(0, 5) == 0) ? 16'h0 :
                  (cmd_op == 3'd3) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      cmd_cin   = 1'($urandom_range(0, 1));
      cmd_tag   = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("drain_rsp_valid", 64'(rsp_valid), 64'(0));
    check("drain_cmd_ready", 64'(cmd_ready), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
